result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader_if.sv | 26 ++
 rtl/result_reader.sv | 143 ++++++++++++++
 tb/tb_result_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/result_reader_if.sv
// Bundle of result_reader ports: dump command, status, memory read lane and byte stream.
// slave is the reader side; master is the side that issues commands, serves memory and consumes bytes.
interface result_reader_if #(
  parameter int WIDTH = 36
);
  logic             start;
  logic [WIDTH-1:0] base_addr;
  logic [WIDTH-1:0] length;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mem_a;
  logic [7:0]       mem_rd;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  start, base_addr, length, mem_rd, out_ready,
    output busy, done, mem_a, out_data, out_valid
  );

  modport master (
    output start, base_addr, length, mem_rd, out_ready,
    input  busy, done, mem_a, out_data, out_valid
  );
endinterface

// File: rtl/result_reader.sv
// Streams length bytes of the result segment (wrapping at DEPTH) over a valid/ready byte port.
// Define RESULT_READER_CHECKSUM_EN to append an 8-bit XOR checksum byte after the data.
//
// state | meaning
// IDLE  | waiting for start; mem_a = 0
// READ  | mem_a = current address, mem_rd captured into out_data
// SEND  | out_data offered until out_valid && out_ready
// CSUM  | checksum byte offered (only with RESULT_READER_CHECKSUM_EN)
// DONE  | one-cycle done pulse, then IDLE
module result_reader #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 100
) (
  input logic            clk,
  input logic            reset,
  result_reader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
`ifdef RESULT_READER_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       out_data_q, out_data_d;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      out_data_q <= '0;
`ifdef RESULT_READER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
`ifdef RESULT_READER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    count_d    = count_q;
    out_data_d = out_data_q;
`ifdef RESULT_READER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = '0;
`ifdef RESULT_READER_CHECKSUM_EN
          csum_d  = '0;
`endif
          if (bus.length != '0) begin
            // Folding the base into the segment keeps mem_a below DEPTH even for a bad base.
            addr_d  = bus.base_addr % DEPTH_W;
            len_d   = bus.length;
            state_d = READ;
          end else begin
`ifdef RESULT_READER_CHECKSUM_EN
            out_data_d = 8'h00;
            state_d    = CSUM;
`else
            state_d    = DONE;
`endif
          end
        end
      end

      READ: begin
        out_data_d = bus.mem_rd;
        state_d    = SEND;
      end

      SEND: begin
        if (bus.out_ready) begin
`ifdef RESULT_READER_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (count_q == len_q - ONE) begin
`ifdef RESULT_READER_CHECKSUM_EN
            out_data_d = csum_q ^ out_data_q;
            state_d    = CSUM;
`else
            state_d    = DONE;
`endif
          end else begin
            count_d = count_q + ONE;
            addr_d  = (addr_q >= LAST) ? '0 : addr_q + ONE;
            state_d = READ;
          end
        end
      end

`ifdef RESULT_READER_CHECKSUM_EN
      CSUM: begin
        if (bus.out_ready) state_d = DONE;
      end
`endif

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.mem_a     = (state_q == READ) ? addr_q : '0;
  assign bus.out_data  = out_data_q;
`ifdef RESULT_READER_CHECKSUM_EN
  assign bus.out_valid = (state_q == SEND) || (state_q == CSUM);
`else
  assign bus.out_valid = (state_q == SEND);
`endif

endmodule

// File: tb/tb_result_reader.sv
// Randomized bench for result_reader; expected bytes/addresses come from a queue model of the segment.
`timescale 1ns/1ps
module tb_result_reader;
  localparam int WIDTH  = 36;
  localparam int DEPTH  = 100;
  localparam int MAXCYC = 3000;
`ifdef RESULT_READER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_reader_if #(.WIDTH(WIDTH)) bus ();
  result_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] ram [DEPTH];
  assign bus.mem_rd = (bus.mem_a < WIDTH'(DEPTH)) ? ram[bus.mem_a[6:0]] : 8'hEE;

  int total = 0;
  int bad   = 0;

  logic [7:0]       got_bytes[$], exp_bytes[$];
  logic [WIDTH-1:0] got_addrs[$], exp_addrs[$];
  int first_valid, done_lat, done_cyc, done_cnt, hold_viol;
  bit timeout, idle_after;
  logic [WIDTH-1:0] done_mema;

  function automatic void build_expect(input longint base, input longint len);
    logic [7:0] x;
    int a;
    x = 8'h00;
    exp_bytes.delete();
    exp_addrs.delete();
    for (longint i = 0; i < len; i++) begin
      a = int'((base + i) % DEPTH);
      exp_addrs.push_back(WIDTH'(a));
      exp_bytes.push_back(ram[a]);
      x ^= ram[a];
    end
    if (CSUM_EN) exp_bytes.push_back(x);
  endfunction

  function automatic int bdiff();
    if (got_bytes.size() != exp_bytes.size())
      return (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    foreach (got_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) return i;
    return -1;
  endfunction

  function automatic int adiff();
    if (got_addrs.size() != exp_addrs.size())
      return (got_addrs.size() < exp_addrs.size()) ? got_addrs.size() : exp_addrs.size();
    foreach (got_addrs[i]) if (got_addrs[i] !== exp_addrs[i]) return i;
    return -1;
  endfunction

  function automatic void fill_ram_random();
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom_range(255));
  endfunction

  // Runs one dump and records what the DUT did; the test tasks judge the records.
  task automatic do_dump(input int base, input int len, input int ready_pct,
                         input int stall_idx, input bit poke);
    int cyc, last_hs, stall_left;
    bit done_seen, stalled;
    logic [7:0] held;
    got_bytes.delete();
    got_addrs.delete();
    first_valid = -1; last_hs = -1; done_lat = -1; done_cyc = -1;
    done_cnt = 0; hold_viol = 0; stall_left = 0; stalled = 1'b0;
    done_seen = 1'b0; held = 8'h00; done_mema = '0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = WIDTH'(base);
    bus.length    = WIDTH'(len);
    bus.out_ready = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < MAXCYC) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++; done_seen = 1'b1; done_cyc = cyc;
        done_lat = cyc - last_hs; done_mema = bus.mem_a;
      end
      if (bus.busy && !bus.out_valid && !bus.done) got_addrs.push_back(bus.mem_a);
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (stall_left > 0) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) hold_viol++;
        stall_left--;
        bus.out_ready = 1'b0;
      end else if (bus.out_valid && !stalled && got_bytes.size() == stall_idx) begin
        stalled = 1'b1; held = bus.out_data; stall_left = 4;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = ($urandom_range(99) < ready_pct);
      end
      if (bus.out_valid && bus.out_ready) begin
        got_bytes.push_back(bus.out_data);
        last_hs = cyc;
      end
      if (poke && bus.busy && !bus.done) begin
        bus.start     = 1'($urandom_range(1));
        bus.base_addr = WIDTH'($urandom_range(DEPTH - 1));
        bus.length    = WIDTH'($urandom_range(1, 9));
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    if (bus.done) done_cnt++;
    idle_after = !bus.busy && (bus.mem_a == '0);
    bus.out_ready = 1'b0;
    timeout = !done_seen;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.base_addr = WIDTH'(5); bus.length = WIDTH'(3);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.out_data); end
    total++; if (bus.mem_a !== '0) begin bad++; $display("FAIL reset_mem_a got=%0d want=0", bus.mem_a); end
    reset = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    ram[10] = 8'h11; ram[11] = 8'h22; ram[12] = 8'h33;
    build_expect(10, 3);
    do_dump(10, 3, 100, -1, 1'b0);
    total++; if (timeout) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
    d = bdiff();
    total++; if (d >= 0) begin bad++; $display("FAIL basic_bytes idx=%0d got_n=%0d want_n=%0d", d, got_bytes.size(), exp_bytes.size()); end
    d = adiff();
    total++; if (d >= 0) begin bad++; $display("FAIL basic_addrs idx=%0d got_n=%0d want_n=%0d", d, got_addrs.size(), exp_addrs.size()); end
    total++; if (first_valid != 2) begin bad++; $display("FAIL basic_first_valid got=%0d want=2", first_valid); end
    total++; if (done_lat != 1) begin bad++; $display("FAIL basic_done_latency got=%0d want=1", done_lat); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulse got=%0d want=1", done_cnt); end
    total++; if (done_mema !== '0) begin bad++; $display("FAIL basic_done_mem_a got=%0d want=0", done_mema); end
    total++; if (!idle_after) begin bad++; $display("FAIL basic_idle_after got=busy want=idle"); end
  endtask

  task automatic test_wrap();
    int d;
    ram[98] = 8'hA1; ram[99] = 8'hA2; ram[0] = 8'hA3; ram[1] = 8'hA4;
    build_expect(98, 4);
    do_dump(98, 4, 100, -1, 1'b0);
    d = adiff();
    total++; if (d >= 0) begin bad++; $display("FAIL wrap_addrs idx=%0d got_n=%0d want_n=%0d", d, got_addrs.size(), exp_addrs.size()); end
    d = bdiff();
    total++; if (d >= 0) begin bad++; $display("FAIL wrap_bytes idx=%0d got_n=%0d want_n=%0d", d, got_bytes.size(), exp_bytes.size()); end
  endtask

  task automatic test_stall();
    int d, base;
    fill_ram_random();
    base = $urandom_range(DEPTH - 1);
    build_expect(base, 4);
    do_dump(base, 4, 100, 1, 1'b0);
    total++; if (hold_viol != 0) begin bad++; $display("FAIL stall_hold got=%0d_changes want=0", hold_viol); end
    d = bdiff();
    total++; if (d >= 0) begin bad++; $display("FAIL stall_bytes idx=%0d got_n=%0d want_n=%0d", d, got_bytes.size(), exp_bytes.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done_pulse got=%0d want=1", done_cnt); end
  endtask

  task automatic test_zero_len();
    int d;
    build_expect(7, 0);
    do_dump(7, 0, 100, -1, 1'b0);
    d = bdiff();
    total++; if (d >= 0) begin bad++; $display("FAIL zero_bytes got_n=%0d want_n=%0d", got_bytes.size(), exp_bytes.size()); end
    total++; if (got_addrs.size() != 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", got_addrs.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_pulse got=%0d want=1", done_cnt); end
    total++; if (done_cyc != (CSUM_EN ? 2 : 1)) begin bad++; $display("FAIL zero_done_cycle got=%0d want=%0d", done_cyc, CSUM_EN ? 2 : 1); end
  endtask

  task automatic test_reset_mid();
    int n, d;
    fill_ram_random();
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = WIDTH'(20); bus.length = WIDTH'(5); bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_reach_send got=%b want=1", bus.out_valid); end
    reset = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", bus.out_data); end
    total++; if (bus.done !== 1'b0 || bus.mem_a !== '0) begin bad++; $display("FAIL rstmid_done_mem_a got=%b/%0d want=0/0", bus.done, bus.mem_a); end
    reset = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
    build_expect(33, 3);
    do_dump(33, 3, 100, -1, 1'b0);
    d = bdiff();
    total++; if (d >= 0) begin bad++; $display("FAIL rstmid_after_bytes idx=%0d got_n=%0d want_n=%0d", d, got_bytes.size(), exp_bytes.size()); end
  endtask

  task automatic test_start_busy();
    int d;
    fill_ram_random();
    build_expect(50, 8);
    do_dump(50, 8, 70, -1, 1'b1);
    d = bdiff();
    total++; if (d >= 0) begin bad++; $display("FAIL busystart_bytes idx=%0d got_n=%0d want_n=%0d", d, got_bytes.size(), exp_bytes.size()); end
    d = adiff();
    total++; if (d >= 0) begin bad++; $display("FAIL busystart_addrs idx=%0d got_n=%0d want_n=%0d", d, got_addrs.size(), exp_addrs.size()); end
    total++; if (done_cnt != 1 || !idle_after) begin bad++; $display("FAIL busystart_finish got=%0d/%b want=1/1", done_cnt, idle_after); end
  endtask

  task automatic test_random();
    int d, base, len;
    fill_ram_random();
    for (int it = 0; it < 20; it++) begin
      base = $urandom_range(DEPTH - 1);
      len  = $urandom_range(1, 25);
      build_expect(base, len);
      do_dump(base, len, $urandom_range(30, 100), -1, 1'b0);
      d = bdiff();
      total++; if (d >= 0) begin bad++; $display("FAIL rand_bytes it=%0d base=%0d len=%0d idx=%0d got_n=%0d want_n=%0d", it, base, len, d, got_bytes.size(), exp_bytes.size()); end
      d = adiff();
      total++; if (d >= 0) begin bad++; $display("FAIL rand_addrs it=%0d base=%0d len=%0d idx=%0d got_n=%0d want_n=%0d", it, base, len, d, got_addrs.size(), exp_addrs.size()); end
      total++; if (done_lat != 1 || done_cnt != 1) begin bad++; $display("FAIL rand_done it=%0d got=%0d/%0d want=1/1", it, done_lat, done_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
